multi_edge_detector: RTL
========================

Name: multi_edge_detector

Overview:
- Parametrised, multi-channel successor to the single-channel level/edge FSM.
- Each of CH channels glitch-filters a raw `level` bit over MIN_W cycles.
- From the filtered signal, each channel generates one-cycle `tick` pulses in one of four runtime modes: rise, fall, both edges, or short-gap detect (high→low→high with a low period of at most GAP_MAX cycles).
- Sits between synchronised external inputs and event-counting/control logic.

Parameters:
CH, 4, number of independent channels (≥1)
MIN_W, 2, consecutive cycles a raw level must hold before it is accepted as a filtered transition (≥1)
GAP_MAX, 1, maximum qualifying low-gap length in edges for mode 3 (≥1)

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high reset
en  in  1  1 = channels advance; 0 = all state and counters hold, ticks forced 0
mode  in  2  0 rise, 1 fall, 2 both, 3 gap; sampled every edge, shared by all channels
level  in  CH  raw per-channel input (already synchronised upstream)
tick  out  CH  registered one-cycle event pulse per channel
filt  out  CH  registered filtered level per channel
any_tick  out  1  registered OR of all tick bits, same cycle as tick

Behaviour:
- Reset: synchronous, active-high, overrides `en`. Reset to 0: every channel state LOW, qual/gap counters, armed, tick, filt, any_tick.
- Reset mid-operation: on the reset edge, pending qualification and armed status are discarded with no tick.
- Per-channel FSM, 4 states:
  - LOW: filt=0.
  - RISE_Q: filt=0, qualifying high.
  - HIGH: filt=1.
  - FALL_Q: filt=1, qualifying low.
- Transitions (only on edges with en=1):
  - LOW: level=1 → RISE_Q, qcnt=1. If MIN_W==1, go directly to HIGH and raise a rise event.
  - RISE_Q: level=0 → LOW (glitch rejected, no event). level=1 and qcnt==MIN_W-1 → HIGH, rise event. Otherwise qcnt+1.
  - HIGH and FALL_Q: symmetric to LOW and RISE_Q with level inverted. A completed fall raises a fall event.
- qcnt width: clog2(MIN_W)+1. qcnt is cleared on every return to LOW or HIGH.
- Latency: a raw change held for MIN_W sampled edges produces the filt change and tick in the cycle after the MIN_W-th edge. A run shorter than MIN_W produces nothing.
- Gap tracking, per channel:
  - armed is set on a fall event; gcnt is cleared to 0 on the same edge.
  - While in LOW or RISE_Q, gcnt increments each edge, saturating at GAP_MAX+1.
  - On the rise event edge, gap = gcnt+1.
  - armed is cleared on any rise event.
- Tick generation, registered on the event edge; tick[i]=1 for exactly one cycle:
  - mode 0: rise event.
  - mode 1: fall event.
  - mode 2: rise or fall event.
  - mode 3: rise event with armed=1 and gap ≤ GAP_MAX. The first rise after reset never ticks.
- With MIN_W=1 and GAP_MAX=1, mode 3 ticks exactly on the pattern 1,0,1 with a single-cycle low.
- Mode change: takes effect at the next edge. Filter and gap state are not reset by a mode change.
- en=0: state, qcnt, gcnt and armed hold; filt holds; tick and any_tick are 0 on the next cycle. en=0 cycles are not counted toward MIN_W or the gap.
- Channels are fully independent. Simultaneous events on several channels each assert their own tick bit, and any_tick=1 once.

Test Plan:
- MIN_W=2, mode 0, level[0]: 0→1 held 4 cycles → filt[0] rises and tick[0]=1 for one cycle, 2 cycles after the first sampled high; any_tick=1 in the same cycle.
- MIN_W=2, level[1] high for 1 cycle only → filt[1] stays 0 and no tick. Repeat for a 1-cycle low dip in HIGH → filt stays 1 and no tick.
- mode 2, level[2] square wave with 5-cycle high and 5-cycle low → tick on every filtered edge, ticks 5 cycles apart, filt tracks the input delayed by MIN_W.
- MIN_W=1, GAP_MAX=1, mode 3, level = 0,1,1,0,1,1,0,0,1 → exactly one tick, on the rise after the 1-cycle low. No tick on the first rise or after the 2-cycle low.
- Channels 0 and 3 rise on the same edge in mode 0 → tick=4'b1001, any_tick=1 for one cycle. Pulse en=0 for 3 cycles mid-qualification → qualification resumes, tick is delayed by 3 cycles, and no tick appears while en=0.
- Assert reset for 1 cycle while channel 0 is in RISE_Q, with level held high → no tick at reset. After reset, qualification restarts: tick in mode 0 after MIN_W edges, no tick in mode 3 (armed=0).

Source files
------------

// File: rtl/multi_edge_detector.sv
// multi_edge_detector: per-channel glitch filter feeding a rise/fall/both/short-gap event generator.
// Latency: filt and tick change in the cycle after the MIN_W-th consecutive qualifying sample.
// Backpressure: none; en=0 freezes every channel and forces tick/any_tick low.
// Ports: clk, reset (sync, active-high), en, mode[1:0] (0 rise, 1 fall, 2 both, 3 gap),
//        level[CH-1:0] raw inputs; tick[CH-1:0] event pulses, filt[CH-1:0] filtered
//        levels, any_tick = OR of tick, aligned with tick.
module multi_edge_detector #(
  parameter int CH      = 4,
  parameter int MIN_W   = 2,
  parameter int GAP_MAX = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [CH-1:0] level,
  output logic [CH-1:0] tick,
  output logic [CH-1:0] filt,
  output logic          any_tick
);

  localparam int QW = $clog2(MIN_W) + 1;
  localparam int GW = $clog2(GAP_MAX + 2);

  localparam logic [QW-1:0] Q_ONE  = QW'(1);
  localparam logic [QW-1:0] Q_LAST = QW'(MIN_W - 1);
  localparam logic [GW-1:0] G_ONE  = GW'(1);
  localparam logic [GW-1:0] G_SAT  = GW'(GAP_MAX + 1);
  localparam logic [GW-1:0] G_MAX  = GW'(GAP_MAX);

  localparam logic [1:0] M_RISE = 2'd0;
  localparam logic [1:0] M_FALL = 2'd1;
  localparam logic [1:0] M_BOTH = 2'd2;

  // Bit 1 of the encoding is the filtered level, so filt comes straight off a flop.
  typedef enum logic [1:0] {
    S_LOW    = 2'b00,
    S_RISE_Q = 2'b01,
    S_HIGH   = 2'b10,
    S_FALL_Q = 2'b11
  } state_t;

  logic [CH-1:0] tick_d;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic            armed_q, armed_d;
    logic            rise_ev, fall_ev, tick_nxt;

    always_comb begin
      state_d  = state_q;
      qcnt_d   = qcnt_q;
      gcnt_d   = gcnt_q;
      armed_d  = armed_q;
      rise_ev  = 1'b0;
      fall_ev  = 1'b0;
      tick_nxt = 1'b0;

      if (en) begin
        unique case (state_q)
          S_LOW: begin
            if (level[i]) begin
              if (MIN_W == 1) begin
                state_d = S_HIGH;
                rise_ev = 1'b1;
              end else begin
                state_d = S_RISE_Q;
                qcnt_d  = Q_ONE;
              end
            end
          end
          S_RISE_Q: begin
            if (!level[i]) begin
              state_d = S_LOW;
              qcnt_d  = '0;
            end else if (qcnt_q == Q_LAST) begin
              state_d = S_HIGH;
              qcnt_d  = '0;
              rise_ev = 1'b1;
            end else begin
              qcnt_d = qcnt_q + Q_ONE;
            end
          end
          S_HIGH: begin
            if (!level[i]) begin
              if (MIN_W == 1) begin
                state_d = S_LOW;
                fall_ev = 1'b1;
              end else begin
                state_d = S_FALL_Q;
                qcnt_d  = Q_ONE;
              end
            end
          end
          S_FALL_Q: begin
            if (level[i]) begin
              state_d = S_HIGH;
              qcnt_d  = '0;
            end else if (qcnt_q == Q_LAST) begin
              state_d = S_LOW;
              qcnt_d  = '0;
              fall_ev = 1'b1;
            end else begin
              qcnt_d = qcnt_q + Q_ONE;
            end
          end
        endcase

        // Gap counter runs whenever the filtered level is low; saturation keeps
        // long gaps disqualified without needing a wide counter.
        if (!state_q[1] && gcnt_q != G_SAT) begin
          gcnt_d = gcnt_q + G_ONE;
        end
        if (fall_ev) begin
          armed_d = 1'b1;
          gcnt_d  = '0;
        end
        if (rise_ev) begin
          armed_d = 1'b0;
        end

        unique case (mode)
          M_RISE:  tick_nxt = rise_ev;
          M_FALL:  tick_nxt = fall_ev;
          M_BOTH:  tick_nxt = rise_ev | fall_ev;
          // gap = gcnt+1 <= GAP_MAX is the same test as gcnt < GAP_MAX.
          default: tick_nxt = rise_ev & armed_q & (gcnt_q < G_MAX);
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= S_LOW;
        qcnt_q  <= '0;
        gcnt_q  <= '0;
        armed_q <= 1'b0;
      end else begin
        state_q <= state_d;
        qcnt_q  <= qcnt_d;
        gcnt_q  <= gcnt_d;
        armed_q <= armed_d;
      end
    end

    assign tick_d[i] = tick_nxt;
    assign filt[i]   = state_q[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick     <= '0;
      any_tick <= 1'b0;
    end else begin
      tick     <= tick_d;
      any_tick <= |tick_d;
    end
  end

endmodule
